// File: rtl/serial_addsub_if.sv
// Handshake/operand bundle for serial_addsub.
// Zero exists only when SERIAL_ADDSUB_ZERO_FLAG_EN is defined.
interface serial_addsub_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Ovf;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
   logic             Zero;

   modport master (output start, sub, A, B, Cin,
                   input  busy, done, Sum, Cout, Ovf, Zero);
   modport slave  (input  start, sub, A, B, Cin,
                   output busy, done, Sum, Cout, Ovf, Zero);
`else
   modport master (output start, sub, A, B, Cin,
                   input  busy, done, Sum, Cout, Ovf);
   modport slave  (input  start, sub, A, B, Cin,
                   output busy, done, Sum, Cout, Ovf);
`endif
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell iterated over WIDTH cycles.
// Optional serially accumulated Zero flag when SERIAL_ADDSUB_ZERO_FLAG_EN is defined.
module serial_addsub #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_addsub_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

   function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
      return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] sum_r;
   logic [CW-1:0]    cnt_r;
   logic             carry_r;
   logic             busy_r;
   logic             done_r;
   logic             cout_r;
   logic             ovf_r;
   logic             load_s;
   logic             step_s;
   logic             finish_s;
   logic             last_s;
   logic [1:0]       fa_s;

   assign last_s = (cnt_r == CW'(WIDTH - 1));
   assign fa_s   = full_add(a_r[0], b_r[0], carry_r);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) state_nxt_s = CALC;
            else           state_nxt_s = IDLE;
         end
         CALC: begin
            if (last_s) state_nxt_s = IDLE;
            else        state_nxt_s = CALC;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath control strobes
   always_comb begin
      load_s   = 1'b0;
      step_s   = 1'b0;
      finish_s = 1'b0;
      case (state_r)
         IDLE: begin
            load_s = bus.start;
         end
         CALC: begin
            step_s   = 1'b1;
            finish_s = last_s;
         end
         default: begin
            load_s   = 1'b0;
            step_s   = 1'b0;
            finish_s = 1'b0;
         end
      endcase
   end

   // Operand shift registers, carry, counter and partial result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         res_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else if (load_s) begin
         // Subtract is A + ~B + 1, so the inversion and the +1 are folded in here.
         a_r     <= bus.A;
         b_r     <= bus.sub ? ~bus.B : bus.B;
         carry_r <= bus.sub ? 1'b1 : bus.Cin;
         res_r   <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
      end else if (step_s) begin
         a_r     <= {1'b0, a_r[WIDTH-1:1]};
         b_r     <= {1'b0, b_r[WIDTH-1:1]};
         res_r   <= {fa_s[0], res_r[WIDTH-1:1]};
         carry_r <= fa_s[1];
         cnt_r   <= cnt_r + CW'(1'b1);
      end
   end

   // Handshake flags and visible results, touched only on load/completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         sum_r  <= {WIDTH{1'b0}};
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         done_r <= finish_s;
         if (load_s) begin
            busy_r <= 1'b1;
         end else if (finish_s) begin
            busy_r <= 1'b0;
            sum_r  <= {fa_s[0], res_r[WIDTH-1:1]};
            cout_r <= fa_s[1];
            ovf_r  <= carry_r ^ fa_s[1];
         end
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.Sum  = sum_r;
   assign bus.Cout = cout_r;
   assign bus.Ovf  = ovf_r;

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
   logic zacc_r;
   logic zero_r;

   // OR-accumulate of emitted sum bits; Zero latched on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zacc_r <= 1'b0;
         zero_r <= 1'b0;
      end else if (load_s) begin
         zacc_r <= 1'b0;
      end else if (step_s) begin
         zacc_r <= zacc_r | fa_s[0];
         if (finish_s) begin
            zero_r <= ~(zacc_r | fa_s[0]);
         end
      end
   end

   assign bus.Zero = zero_r;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: stimulus pushes model results, a monitor pops on done.
module tb_serial_addsub;
   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      logic             zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   exp_t held;
   logic prev_done = 1'b0;

   serial_addsub_if #(.WIDTH(WIDTH)) bus ();
   serial_addsub #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic s);
      exp_t   e;
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint smax = (longint'(1) <<< (WIDTH - 1)) - 1;
      longint smin = -(longint'(1) <<< (WIDTH - 1));
      longint ures;
      longint sres;
      if (!s) begin
         ures   = ua + ub + longint'(cin);
         sres   = sa + sb + longint'(cin);
         e.cout = ures[WIDTH];
      end else begin
         ures   = ua - ub;
         sres   = sa - sb;
         e.cout = (ua >= ub);
      end
      e.sum  = ures[WIDTH-1:0];
      e.ovf  = (sres > smax) || (sres < smin);
      e.zero = (e.sum == '0);
      return e;
   endfunction

   task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare on done, and verify results hold while busy.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.done === 1'b1) begin
            check1("done_pulse_width", 64'(prev_done), 64'(0));
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
               held = sb_q.pop_front();
               check1("sum", 64'(bus.Sum), 64'(held.sum));
               check1("cout", 64'(bus.Cout), 64'(held.cout));
               check1("ovf", 64'(bus.Ovf), 64'(held.ovf));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
               check1("zero", 64'(bus.Zero), 64'(held.zero));
`endif
            end
         end else if (bus.busy === 1'b1) begin
            check1("sum_hold", 64'(bus.Sum), 64'(held.sum));
            check1("cout_hold", 64'(bus.Cout), 64'(held.cout));
         end
         prev_done = bus.done;
      end else begin
         prev_done = 1'b0;
      end
   end

   task automatic scramble();
      bus.A   = WIDTH'($urandom);
      bus.B   = WIDTH'($urandom);
      bus.Cin = 1'($urandom);
      bus.sub = 1'($urandom);
   endtask

   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic s, input bit push);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A = a;
      bus.B = b;
      bus.Cin = cin;
      bus.sub = s;
      @(posedge clk);
      if (push) sb_q.push_back(model(a, b, cin, s));
      #1;
      bus.start = 1'b0;
      scramble();
   endtask

   // Counts edges after the start edge until done; optionally injects a stray start.
   task automatic wait_done(input int pulse_at);
      int n = 0;
      while (n < WIDTH + 4) begin
         if (n == pulse_at) begin
            bus.start = 1'b1;
            scramble();
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         n++;
         #1;
         if (bus.done === 1'b1) break;
      end
      bus.start = 1'b0;
      check1("latency", 64'(n), 64'(WIDTH));
   endtask

   task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic s);
      issue(a, b, cin, s, 1'b1);
      wait_done(-1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      held = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.Cin = 1'b0;
      bus.sub = 1'b0;

      // asynchronous reset, observed before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check1("rst_busy", 64'(bus.busy), 64'(0));
      check1("rst_done", 64'(bus.done), 64'(0));
      check1("rst_sum", 64'(bus.Sum), 64'(0));
      check1("rst_cout", 64'(bus.Cout), 64'(0));
      check1("rst_ovf", 64'(bus.Ovf), 64'(0));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      check1("rst_zero", 64'(bus.Zero), 64'(0));
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // directed cases, issued back-to-back in each done cycle
      run(8'h0F, 8'h01, 1'b0, 1'b0);
      run(8'h7F, 8'h01, 1'b0, 1'b0);
      run(8'hFF, 8'h01, 1'b1, 1'b0);
      run(8'h05, 8'h07, 1'b1, 1'b1);
      run(8'h80, 8'h01, 1'b0, 1'b1);

      // stray start three cycles into an operation must be ignored
      issue(8'h3C, 8'h21, 1'b0, 1'b0, 1'b1);
      wait_done(3);

`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
      run(8'h80, 8'h80, 1'b0, 1'b1);
      run(8'h01, 8'h00, 1'b0, 1'b0);
`endif

      // abort mid-operation after four CALC edges
      issue(8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      held = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
      check1("abort_busy", 64'(bus.busy), 64'(0));
      check1("abort_done", 64'(bus.done), 64'(0));
      check1("abort_sum", 64'(bus.Sum), 64'(0));
      check1("abort_cout", 64'(bus.Cout), 64'(0));
      check1("abort_ovf", 64'(bus.Ovf), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (WIDTH + 4) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      check1("abort_no_done", 64'(seen), 64'(0));

      // randomized operations with random idle gaps and stray starts
      for (int i = 0; i < 40; i++) begin
         logic [WIDTH-1:0] ra;
         logic [WIDTH-1:0] rb;
         logic rc;
         logic rs;
         int   gap;
         ra  = WIDTH'($urandom);
         rb  = WIDTH'($urandom);
         rc  = 1'($urandom);
         rs  = 1'($urandom);
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(posedge clk);
         issue(ra, rb, rc, rs, 1'b1);
         if ($urandom_range(0, 3) == 0) wait_done(int'($urandom_range(0, WIDTH - 2)));
         else wait_done(-1);
      end

      repeat (3) @(negedge clk);
      check1("queue_empty", 64'(sb_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor.
- Built around a single full-adder cell, iterated over WIDTH clock cycles with a registered carry.
- Replaces a WIDTH-bit ripple array where area matters more than latency; sits in Arithmetic-Circuits alongside the combinational adders.
- Start/done handshake. Carry-out and signed-overflow flags are produced.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled only while idle
- sub    input   1      0 = add, 1 = subtract; captured at start
- A      input   WIDTH  operand A; captured at start
- B      input   WIDTH  operand B; captured at start
- Cin    input   1      carry-in for add; ignored for subtract; captured at start
- busy   output  1      high while an operation is in progress
- done   output  1      one-cycle pulse when Sum/Cout/Ovf are valid
- Sum    output  WIDTH  result
- Cout   output  1      final carry-out; in subtract, 1 = no borrow
- Ovf    output  1      two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE; busy=0, done=0, Sum=0, Cout=0, Ovf=0; internal shift registers, carry and bit counter all 0.
- States: IDLE, CALC.
- IDLE, start=1 at a clock edge:
  - Capture A and B into shift registers.
  - Capture operand B as B (add) or ~B (subtract).
  - Carry register <= Cin (add) or 1 (subtract).
  - Bit counter <= 0; state -> CALC; busy -> 1.
- IDLE, start=0: remain in IDLE; outputs hold their last values.
- CALC, each edge:
  - Full-add the LSBs of both shift registers with the carry register.
  - Shift the sum bit into the MSB of the result register (result emerges LSB-first, fully aligned after WIDTH shifts).
  - Shift both operand registers right by one. Update carry; increment counter.
- CALC, edge where counter == WIDTH-1 (the WIDTH-th CALC edge):
  - Sum <= final result register value; Cout <= final carry.
  - Ovf <= carry into MSB XOR carry out of MSB.
  - state -> IDLE; busy -> 0; done -> 1.
- Latency: done is high in the cycle following the WIDTH-th edge after the start-sampling edge; done lasts exactly one cycle.
- Sum/Cout/Ovf update only on the completing edge. They are not disturbed during CALC and hold until the next completion.
- Results:
  - Add: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1).
  - Subtract: Sum = (A - B) mod 2^WIDTH; Cout = (A >= B unsigned); Ovf per signed A - B.
- start while busy=1: ignored; captured operands unaffected.
- start in the done cycle: accepted (state is IDLE). Back-to-back throughput is one result per WIDTH+1 cycles.
- A/B/Cin/sub changing during CALC: no effect.
- rst_n low mid-operation: immediate abort to reset values; no done pulse is produced for the aborted operation.

Optional Feature:
- Macro: SERIAL_ADDSUB_ZERO_FLAG_EN.
- Defined:
  - Extra output port Zero (1 bit), reset 0.
  - Updated on the completing edge: Zero=1 iff the final Sum is all zeros.
  - Holds with Sum.
  - Computed serially as an OR-accumulate of sum bits during CALC, not by a WIDTH-wide reduction.
- Not defined: Zero port and its logic absent; all other behaviour identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with no clock edge -> busy=0, done=0, Sum=8'h00, Cout=0, Ovf=0 immediately.
- Add, WIDTH=8: A=8'h0F, B=8'h01, Cin=0 -> done exactly 8 edges after start edge; Sum=8'h10, Cout=0, Ovf=0. Then A=8'h7F, B=8'h01, Cin=0 -> Sum=8'h80, Ovf=1, Cout=0. Then A=8'hFF, B=8'h01, Cin=1 -> Sum=8'h01, Cout=1, Ovf=0.
- Subtract: A=8'h05, B=8'h07, sub=1, Cin=1 (ignored) -> Sum=8'hFE, Cout=0, Ovf=0. Then A=8'h80, B=8'h01, sub=1 -> Sum=8'h7F, Cout=1, Ovf=1.
- Handshake:
  - Pulse start again 3 cycles into an operation with different operands -> ignored; first result unchanged.
  - Assert start in the done cycle -> second operation accepted; its done arrives 8 edges later.
- Reset mid-op: start A=8'hAA, B=8'h55; drop rst_n after 4 CALC edges -> no done pulse; all outputs 0.
- Zero flag (macro defined): A=8'h80, B=8'h80, sub=1 -> Sum=8'h00, Zero=1, Cout=1. Then 8'h01+8'h00 -> Zero=0.
